sha3_padder: RTL and testbench

Upstream message packer for the `keccak_big` permutation core. It accepts a little-endian 64-bit word stream and packs it into rate-sized blocks for SHA3-256 (rate 1088 bits, 17 lanes). It applies SHA3 domain padding (0x06 … 0x80) and presents each 1600-bit block to the core over a valid/ready handshake. Its block output drives the core's `Din`, `Din_valid` and `Last_block` inputs, and its `blk_ready` input is driven by the core's `Ready`.

---
 rtl/sha3_padder.sv | 150 +++++++++++++++
 tb/tb_sha3_padder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_padder.sv
// SHA3-256 message packer: gathers 64-bit little-endian words into 17-lane rate blocks,
// applies 0x06..0x80 domain padding and hands each 1600-bit block to keccak_big.
module sha3_padder #(
   parameter int WIDTH      = 64,
   parameter int RATE_LANES = 17
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic [WIDTH-1:0]             in_data,
   input  logic [3:0]                   in_bytes,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [0:4][0:4][WIDTH-1:0]   Dblk,
   output logic                         blk_valid,
   output logic                         blk_last,
   input  logic                         blk_ready,
   output logic [4:0]                   lane_cnt
);

   localparam logic [4:0]       LAST_LANE = 5'(RATE_LANES - 1);
   localparam logic [WIDTH-1:0] DOM_PAD   = WIDTH'(8'h06);
   localparam logic [WIDTH-1:0] END_PAD   = {8'h80, {(WIDTH-8){1'b0}}};

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_EMIT   = 2'd1,
      S_PADBLK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lane_q [RATE_LANES];
   logic [WIDTH-1:0] lane_d [RATE_LANES];
   logic [4:0]       cnt_q, cnt_d;
   logic [4:0]       cnt_nxt;
   logic             pend_q, pend_d;
   logic             in_ready_q, in_ready_d;
   logic             blk_valid_q, blk_valid_d;
   logic             blk_last_q, blk_last_d;
   logic             accept;

   function automatic logic [WIDTH-1:0] low_bytes(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       b);
      logic [WIDTH-1:0] mask;
      mask = (WIDTH'(1) << {b, 3'b000}) - WIDTH'(1);
      return d & mask;
   endfunction

   assign accept  = (state_q == S_FILL) && in_valid && in_ready_q;
   assign cnt_nxt = cnt_q + 5'd1;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      blk_last_d = blk_last_q;
      case (state_q)
         S_FILL: begin
            if (accept) begin
               if (!in_last) begin
                  lane_d[cnt_q] = in_data;
                  if (cnt_q == LAST_LANE) begin
                     cnt_d      = 5'd0;
                     state_d    = S_EMIT;
                     blk_last_d = 1'b0;
                  end else begin
                     cnt_d = cnt_nxt;
                  end
               end else if (!in_bytes[3]) begin
                  // Partial final word: domain byte lands right after the data bytes
                  lane_d[cnt_q]     = low_bytes(in_data, in_bytes[2:0])
                                      | (DOM_PAD << {in_bytes[2:0], 3'b000});
                  lane_d[LAST_LANE] = lane_d[LAST_LANE] | END_PAD;
                  state_d    = S_EMIT;
                  blk_last_d = 1'b1;
               end else if (cnt_q != LAST_LANE) begin
                  lane_d[cnt_q]     = in_data;
                  lane_d[cnt_nxt]   = DOM_PAD;
                  lane_d[LAST_LANE] = lane_d[LAST_LANE] | END_PAD;
                  state_d    = S_EMIT;
                  blk_last_d = 1'b1;
               end else begin
                  // Full word fills the block exactly: padding needs a block of its own
                  lane_d[LAST_LANE] = in_data;
                  state_d    = S_EMIT;
                  blk_last_d = 1'b0;
                  pend_d     = 1'b1;
               end
            end
         end
         S_EMIT: begin
            if (blk_ready) begin
               lane_d     = '{default: '0};
               cnt_d      = 5'd0;
               blk_last_d = 1'b0;
               state_d    = pend_q ? S_PADBLK : S_FILL;
            end
         end
         S_PADBLK: begin
            lane_d[0]         = DOM_PAD;
            lane_d[LAST_LANE] = END_PAD;
            pend_d     = 1'b0;
            blk_last_d = 1'b1;
            state_d    = S_EMIT;
         end
         default: state_d = S_FILL;
      endcase
      in_ready_d  = (state_d == S_FILL);
      blk_valid_d = (state_d == S_EMIT);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_FILL;
         lane_q      <= '{default: '0};
         cnt_q       <= 5'd0;
         pend_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         blk_valid_q <= 1'b0;
         blk_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         in_ready_q  <= in_ready_d;
         blk_valid_q <= blk_valid_d;
         blk_last_q  <= blk_last_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign blk_valid = blk_valid_q;
   assign blk_last  = blk_last_q;
   assign lane_cnt  = cnt_q;

   // Lane k sits at Dblk[k%5][k/5]; capacity lanes are always zero
   for (genvar x = 0; x < 5; x++) begin : g_x
      for (genvar y = 0; y < 5; y++) begin : g_y
         localparam int K = x + 5 * y;
         if (K < RATE_LANES) begin : g_rate
            assign Dblk[x][y] = lane_q[K];
         end else begin : g_cap
            assign Dblk[x][y] = '0;
         end
      end
   end

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder: hand-computed padded blocks for the SHA3-256 rate.
module tb_sha3_padder;

   logic                      clk;
   logic                      nrst;
   logic [63:0]               in_data;
   logic [3:0]                in_bytes;
   logic                      in_valid;
   logic                      in_last;
   logic                      in_ready;
   logic [0:4][0:4][63:0]     Dblk;
   logic                      blk_valid;
   logic                      blk_last;
   logic                      blk_ready;
   logic [4:0]                lane_cnt;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_l [25];

   localparam logic [63:0] A3  = 64'hA3A3A3A3A3A3A3A3;
   localparam logic [63:0] DOM = 64'h0000000000000006;
   localparam logic [63:0] END = 64'h8000000000000000;

   sha3_padder #(.WIDTH(64), .RATE_LANES(17)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_data   (in_data),
      .in_bytes  (in_bytes),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .Dblk      (Dblk),
      .blk_valid (blk_valid),
      .blk_last  (blk_last),
      .blk_ready (blk_ready),
      .lane_cnt  (lane_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      for (int k = 0; k < 25; k++) exp_l[k] = 64'd0;
   endtask

   task automatic chk_blk(input string tag);
      for (int k = 0; k < 25; k++)
         chk($sformatf("%s_lane%0d", tag, k), Dblk[k % 5][k / 5], exp_l[k]);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [63:0] d, input logic [3:0] b, input logic l);
      int n;
      in_data  = d;
      in_bytes = b;
      in_last  = l;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic transfer();
      blk_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      blk_ready = 1'b0;
   endtask

   initial begin
      nrst      = 1'b0;
      in_data   = 64'd0;
      in_bytes  = 4'd0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      blk_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
      chk("rst_blk_valid", {63'd0, blk_valid}, 64'd0);
      chk("rst_blk_last",  {63'd0, blk_last},  64'd0);
      chk("rst_lane_cnt",  {59'd0, lane_cnt},  64'd0);
      chk("rst_lane0",     Dblk[0][0],         64'd0);
      nrst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Empty message
      send(64'd0, 4'd0, 1'b1);
      chk("empty_latency", {63'd0, blk_valid}, 64'd1);
      chk("empty_in_ready", {63'd0, in_ready}, 64'd0);
      chk("empty_last", {63'd0, blk_last}, 64'd1);
      clear_exp();
      exp_l[0]  = DOM;
      exp_l[16] = END;
      chk_blk("empty");
      transfer();
      chk("empty_after_valid", {63'd0, blk_valid}, 64'd0);
      chk("empty_after_ready", {63'd0, in_ready},  64'd1);
      chk("empty_after_cnt",   {59'd0, lane_cnt},  64'd0);
      chk("empty_after_lane0", Dblk[0][0],         64'd0);

      // "abc" with 5 cycles of backpressure
      send(64'hFFFF_FFFF_FF63_6261, 4'd3, 1'b1);
      clear_exp();
      exp_l[0]  = 64'h0000000006636261;
      exp_l[16] = END;
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid",    {63'd0, blk_valid}, 64'd1);
         chk("bp_in_ready", {63'd0, in_ready},  64'd0);
         chk("bp_last",     {63'd0, blk_last},  64'd1);
         chk("bp_lane0",    Dblk[0][0], exp_l[0]);
         @(negedge clk);
      end
      chk_blk("abc");
      transfer();
      chk("abc_one_xfer", {63'd0, blk_valid}, 64'd0);
      repeat (3) @(negedge clk);
      chk("abc_no_second", {63'd0, blk_valid}, 64'd0);

      // One full final word at lane 0
      send(64'h0807060504030201, 4'd8, 1'b1);
      clear_exp();
      exp_l[0]  = 64'h0807060504030201;
      exp_l[1]  = DOM;
      exp_l[16] = END;
      chk("w8_last", {63'd0, blk_last}, 64'd1);
      chk_blk("w8");
      transfer();

      // 135 bytes: final byte of padding shares byte 7 of lane 16
      for (int i = 0; i < 16; i++) send(A3, 4'd8, 1'b0);
      chk("b135_cnt", {59'd0, lane_cnt}, 64'd16);
      send(64'h00A3A3A3A3A3A3A3, 4'd7, 1'b1);
      clear_exp();
      for (int k = 0; k < 16; k++) exp_l[k] = A3;
      exp_l[16] = 64'h86A3A3A3A3A3A3A3;
      chk("b135_last", {63'd0, blk_last}, 64'd1);
      chk_blk("b135");
      transfer();
      chk("b135_done", {63'd0, blk_valid}, 64'd0);

      // 128 bytes: full last word at lane 15
      for (int i = 0; i < 15; i++) send(A3, 4'd8, 1'b0);
      send(A3, 4'd8, 1'b1);
      clear_exp();
      for (int k = 0; k < 16; k++) exp_l[k] = A3;
      exp_l[16] = 64'h8000000000000006;
      chk("b128_last", {63'd0, blk_last}, 64'd1);
      chk_blk("b128");
      transfer();

      // 136 bytes: data block, then a padding-only block
      for (int i = 0; i < 16; i++) send(A3, 4'd8, 1'b0);
      send(A3, 4'd8, 1'b1);
      chk("b136_valid1", {63'd0, blk_valid}, 64'd1);
      chk("b136_last1",  {63'd0, blk_last},  64'd0);
      clear_exp();
      for (int k = 0; k < 17; k++) exp_l[k] = A3;
      chk_blk("b136_blk1");
      transfer();
      chk("b136_pad_valid", {63'd0, blk_valid}, 64'd0);
      chk("b136_pad_ready", {63'd0, in_ready},  64'd0);
      @(negedge clk);
      chk("b136_valid2", {63'd0, blk_valid}, 64'd1);
      chk("b136_last2",  {63'd0, blk_last},  64'd1);
      clear_exp();
      exp_l[0]  = DOM;
      exp_l[16] = END;
      chk_blk("b136_blk2");
      transfer();
      chk("b136_end_ready", {63'd0, in_ready}, 64'd1);

      // Reset mid-fill discards the partial block
      for (int i = 0; i < 5; i++) send(64'h1111111111111111, 4'd8, 1'b0);
      chk("mid_cnt5", {59'd0, lane_cnt}, 64'd5);
      nrst = 1'b0;
      #1;
      chk("mid_rst_cnt",   {59'd0, lane_cnt},  64'd0);
      chk("mid_rst_valid", {63'd0, blk_valid}, 64'd0);
      chk("mid_rst_ready", {63'd0, in_ready},  64'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk("mid_no_blk", {63'd0, blk_valid}, 64'd0);
      send(64'h0000000000636261, 4'd3, 1'b1);
      clear_exp();
      exp_l[0]  = 64'h0000000006636261;
      exp_l[16] = END;
      chk("mid_abc_last", {63'd0, blk_last}, 64'd1);
      chk_blk("mid_abc");
      transfer();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
